// File: rtl/amber_trap_return.sv
// RETT sequencer: reads LR from the SR file, validates it, then redirects fetch or raises a return fault.
// Also tracks the trap nesting depth, which trap entry increments and a completed return decrements.
module amber_trap_return #(
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned SR_IDX_W  = 4,
  parameter int unsigned SR_IDX_LR = 1,
  parameter int unsigned NEST_MAX  = 4
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_trap_taken,
  input  logic                iw_rett_valid,
  output logic                ow_rett_ack,
  output logic                ow_sr_rd_en,
  output logic [SR_IDX_W-1:0] ow_sr_rd_idx,
  input  logic [ADDR_W-1:0]   iw_sr_rd_data,
  output logic                ow_redir_valid,
  input  logic                iw_redir_ready,
  output logic [ADDR_W-1:0]   ow_redir_pc,
  output logic                ow_stall,
  output logic                ow_in_trap,
  output logic [2:0]          ow_nest_depth,
  output logic                ow_fault_valid,
  output logic [1:0]          ow_fault_code
);

  localparam int unsigned DEPTH_W = 3;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NEST_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RDLR  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_REDIR = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [1:0] FC_LR_ZERO  = 2'd1;
  localparam logic [1:0] FC_DEPTH0   = 2'd2;
  localparam logic [1:0] FC_OVERFLOW = 2'd3;

  logic [2:0]         state, state_nxt;
  logic [DEPTH_W-1:0] depth, depth_nxt;
  logic [1:0]         code_q, code_nxt;
  logic [ADDR_W-1:0]  pc_q, pc_nxt;
  logic               rd_en_q, stall_q, in_trap_q, redir_valid_q, fault_q;
  logic               handshake, overflow;

  // State, depth and registered outputs.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state         <= S_IDLE;
      depth         <= '0;
      code_q        <= '0;
      pc_q          <= '0;
      rd_en_q       <= 1'b0;
      stall_q       <= 1'b0;
      in_trap_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      depth         <= depth_nxt;
      code_q        <= code_nxt;
      pc_q          <= pc_nxt;
      rd_en_q       <= (state_nxt == S_RDLR);
      stall_q       <= (state_nxt != S_IDLE);
      in_trap_q     <= (depth_nxt != '0);
      redir_valid_q <= (state_nxt == S_REDIR);
      fault_q       <= (state_nxt == S_FAULT);
    end
  end

  // Next-state and depth logic; a trap entry overrides any RETT in flight.
  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    code_nxt  = code_q;
    pc_nxt    = pc_q;
    handshake = (state == S_REDIR) && iw_redir_ready;
    overflow  = iw_trap_taken && (depth == DEPTH_MAX);

    case (state)
      S_IDLE:  if (iw_rett_valid) state_nxt = S_RDLR;
      S_RDLR:  state_nxt = S_CHECK;
      S_CHECK: begin
        pc_nxt = iw_sr_rd_data;
        if (depth == '0) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_DEPTH0;
        end else if (iw_sr_rd_data == '0) begin
          state_nxt = S_FAULT;
          code_nxt  = FC_LR_ZERO;
        end else begin
          state_nxt = S_REDIR;
        end
      end
      S_REDIR: begin
        if (handshake) begin
          state_nxt = S_IDLE;
          depth_nxt = depth - DEPTH_W'(1);
        end
      end
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (iw_trap_taken) begin
      state_nxt = S_IDLE;
      code_nxt  = code_q;
      depth_nxt = overflow ? depth : depth + DEPTH_W'(1);
    end
  end

  // Ack and the overflow fault must land in the same cycle as their cause.
  assign ow_rett_ack    = ((redir_valid_q && iw_redir_ready) || fault_q) && !iw_trap_taken;
  assign ow_fault_valid = (fault_q && !iw_trap_taken) || overflow;
  assign ow_fault_code  = overflow ? FC_OVERFLOW : code_q;

  assign ow_sr_rd_en    = rd_en_q;
  assign ow_sr_rd_idx   = SR_IDX_W'(SR_IDX_LR);
  assign ow_redir_valid = redir_valid_q;
  assign ow_redir_pc    = pc_q;
  assign ow_stall       = stall_q;
  assign ow_in_trap     = in_trap_q;
  assign ow_nest_depth  = depth;

endmodule
